// File: rtl/pong_pkg.sv
// Purpose: shared match-phase encoding, score width and serve-direction constants.
// Latency: none (declarations only).
// Backpressure: none.
package pong_pkg;

  localparam int SCORE_W_DEF = 8;

  // Serve direction, also reused as the WINNER encoding (0 = A, 1 = B)
  localparam logic DIR_A = 1'b0;
  localparam logic DIR_B = 1'b1;

  // Encoding is visible on the STATE debug output and read by the overlay
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SERVE_WAIT = 3'd1,
    ST_PLAY       = 3'd2,
    ST_PAUSED     = 3'd3,
    ST_GAME_OVER  = 3'd4
  } state_t;

endpackage

// File: rtl/pong_if.sv
// Purpose: bundles the match controller's engine/renderer facing signals.
// Latency: none (wiring only).
// Backpressure: none; every signal is a level or a single-cycle pulse.
interface pong_if
  import pong_pkg::*;
#(
  parameter int SCORE_W = SCORE_W_DEF
);
  logic               FRAME_TICK;
  logic               START_BTN;
  logic               PAUSE_BTN;
  logic               MISS_A;
  logic               MISS_B;
  logic               BALL_ENABLE;
  logic               SERVE;
  logic               SERVE_DIR;
  logic [SCORE_W-1:0] SCORE_A;
  logic [SCORE_W-1:0] SCORE_B;
  logic               GAME_OVER;
  logic               WINNER;
  logic [2:0]         STATE;

  // Controller side
  modport master (
    input  FRAME_TICK, START_BTN, PAUSE_BTN, MISS_A, MISS_B,
    output BALL_ENABLE, SERVE, SERVE_DIR, SCORE_A, SCORE_B, GAME_OVER, WINNER, STATE
  );

  // Engine / renderer / button side
  modport slave (
    output FRAME_TICK, START_BTN, PAUSE_BTN, MISS_A, MISS_B,
    input  BALL_ENABLE, SERVE, SERVE_DIR, SCORE_A, SCORE_B, GAME_OVER, WINNER, STATE
  );

endinterface

// File: rtl/button_edge.sv
// Purpose: registered rising-edge detector for a debounced button level.
// Latency: rise is high for the one cycle after the input is first seen high.
// Backpressure: none; history resets to 1 so a button held through reset gives no edge.
module button_edge (
  input  logic VGA_CLOCK,
  input  logic RESET,
  input  logic btn,
  output logic rise
);

  logic btn_q;

  // Track previous level and register the rise
  always_ff @(posedge VGA_CLOCK) begin
    if (RESET) begin
      btn_q <= 1'b1;
      rise  <= 1'b0;
    end else begin
      btn_q <= btn;
      rise  <= btn & ~btn_q;
    end
  end

endmodule

// File: rtl/pong_match_controller.sv
// Purpose: pong match sequencer owning phases, scores, serve timing and win decision.
// Latency: all outputs registered; button edges act one cycle after the input rises.
// Backpressure: none; FRAME_TICK/MISS pulses are consumed or ignored in the cycle they arrive.
module pong_match_controller
  import pong_pkg::*;
#(
  parameter int WIN_SCORE          = 11,
  parameter int SERVE_DELAY_FRAMES = 60,
  parameter int SCORE_W            = SCORE_W_DEF
) (
  input  logic   VGA_CLOCK,
  input  logic   RESET,
  pong_if.master bus
);

  localparam int                 CNT_W     = $clog2(SERVE_DELAY_FRAMES + 1);
  localparam logic [CNT_W-1:0]   CNT_LOAD  = CNT_W'(SERVE_DELAY_FRAMES);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);

  logic start_rise, pause_rise;

  button_edge u_start_edge (
    .VGA_CLOCK (VGA_CLOCK),
    .RESET     (RESET),
    .btn       (bus.START_BTN),
    .rise      (start_rise)
  );

  button_edge u_pause_edge (
    .VGA_CLOCK (VGA_CLOCK),
    .RESET     (RESET),
    .btn       (bus.PAUSE_BTN),
    .rise      (pause_rise)
  );

  state_t             state_q, state_d, saved_q, saved_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SCORE_W-1:0] score_a_q, score_a_d, score_b_q, score_b_d;
  logic               dir_q, dir_d, winner_q, winner_d;
  logic               serve_q, serve_d, ball_q, ball_d, over_q, over_d;

  // Next-state, scoring and serve-countdown decisions
  always_comb begin
    state_d   = state_q;
    saved_d   = saved_q;
    cnt_d     = cnt_q;
    score_a_d = score_a_q;
    score_b_d = score_b_q;
    dir_d     = dir_q;
    winner_d  = winner_q;
    serve_d   = 1'b0;
    case (state_q)
      ST_IDLE, ST_GAME_OVER: begin
        if (start_rise) begin
          score_a_d = '0;
          score_b_d = '0;
          dir_d     = DIR_A;
          cnt_d     = CNT_LOAD;
          state_d   = ST_SERVE_WAIT;
        end
      end
      ST_SERVE_WAIT: begin
        // A pause edge freezes the countdown even if a tick lands in the same cycle
        if (pause_rise) begin
          saved_d = ST_SERVE_WAIT;
          state_d = ST_PAUSED;
        end else if (bus.FRAME_TICK) begin
          if (cnt_q <= CNT_ONE) begin
            cnt_d   = '0;
            serve_d = 1'b1;
            state_d = ST_PLAY;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end
      ST_PLAY: begin
        // Misses outrank a simultaneous pause edge; MISS_A outranks MISS_B
        if (bus.MISS_A) begin
          score_b_d = score_b_q + SCORE_ONE;
          dir_d     = DIR_A;
          if (score_b_d == WIN_VAL) begin
            winner_d = DIR_B;
            state_d  = ST_GAME_OVER;
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = ST_SERVE_WAIT;
          end
        end else if (bus.MISS_B) begin
          score_a_d = score_a_q + SCORE_ONE;
          dir_d     = DIR_B;
          if (score_a_d == WIN_VAL) begin
            winner_d = DIR_A;
            state_d  = ST_GAME_OVER;
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = ST_SERVE_WAIT;
          end
        end else if (pause_rise) begin
          saved_d = ST_PLAY;
          state_d = ST_PAUSED;
        end
      end
      ST_PAUSED: begin
        if (pause_rise) begin
          state_d = saved_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    ball_d = (state_d == ST_PLAY);
    over_d = (state_d == ST_GAME_OVER);
  end

  // State, counter, scores and registered outputs
  always_ff @(posedge VGA_CLOCK) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      saved_q   <= ST_IDLE;
      cnt_q     <= '0;
      score_a_q <= '0;
      score_b_q <= '0;
      dir_q     <= DIR_A;
      winner_q  <= DIR_A;
      serve_q   <= 1'b0;
      ball_q    <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      saved_q   <= saved_d;
      cnt_q     <= cnt_d;
      score_a_q <= score_a_d;
      score_b_q <= score_b_d;
      dir_q     <= dir_d;
      winner_q  <= winner_d;
      serve_q   <= serve_d;
      ball_q    <= ball_d;
      over_q    <= over_d;
    end
  end

  assign bus.STATE       = state_q;
  assign bus.SCORE_A     = score_a_q;
  assign bus.SCORE_B     = score_b_q;
  assign bus.SERVE_DIR   = dir_q;
  assign bus.WINNER      = winner_q;
  assign bus.SERVE       = serve_q;
  assign bus.BALL_ENABLE = ball_q;
  assign bus.GAME_OVER   = over_q;

endmodule

// File: tb/tb_pong_match_controller.sv
// Purpose: self-checking bench for pong_match_controller (WIN_SCORE=3, 2-frame serve delay).
// Latency: outputs compared every cycle on the falling edge against a match-rules model.
// Backpressure: none.
module tb_pong_match_controller;

  localparam int WS  = 3;
  localparam int SFD = 2;

  logic VGA_CLOCK = 1'b0;
  logic RESET;

  pong_if #(.SCORE_W(8)) bus ();

  pong_match_controller #(
    .WIN_SCORE          (WS),
    .SERVE_DELAY_FRAMES (SFD),
    .SCORE_W            (8)
  ) dut (
    .VGA_CLOCK (VGA_CLOCK),
    .RESET     (RESET),
    .bus       (bus)
  );

  always #5 VGA_CLOCK = ~VGA_CLOCK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- match-rules model ----------------
  // Phases numbered as the STATE output reports them
  localparam int P_IDLE = 0, P_WAIT = 1, P_PLAY = 2, P_PAUSE = 3, P_OVER = 4;

  int m_ph, m_ret, m_sa, m_sb, m_ticks;
  int m_dir, m_win, m_srv;
  int st_prev, pa_prev, st_ev, pa_ev;
  bit chk_en = 1'b0;

  // Applies the match rules once per clock edge
  always @(posedge VGA_CLOCK) begin
    if (RESET) begin
      m_ph = P_IDLE; m_ret = P_IDLE; m_sa = 0; m_sb = 0; m_ticks = 0;
      m_dir = 0; m_win = 0; m_srv = 0;
      st_prev = 1; pa_prev = 1; st_ev = 0; pa_ev = 0;
    end else begin
      m_srv = 0;
      case (m_ph)
        P_IDLE, P_OVER: if (st_ev != 0) begin
          m_sa = 0; m_sb = 0; m_dir = 0; m_ticks = 0; m_ph = P_WAIT;
        end
        P_WAIT: begin
          if (pa_ev != 0) begin
            m_ret = P_WAIT; m_ph = P_PAUSE;
          end else if (bus.FRAME_TICK) begin
            m_ticks++;
            if (m_ticks == SFD) begin m_ph = P_PLAY; m_srv = 1; end
          end
        end
        P_PLAY: begin
          if (bus.MISS_A) begin
            m_sb++; m_dir = 0;
            if (m_sb == WS) begin m_ph = P_OVER; m_win = 1; end
            else begin m_ph = P_WAIT; m_ticks = 0; end
          end else if (bus.MISS_B) begin
            m_sa++; m_dir = 1;
            if (m_sa == WS) begin m_ph = P_OVER; m_win = 0; end
            else begin m_ph = P_WAIT; m_ticks = 0; end
          end else if (pa_ev != 0) begin
            m_ret = P_PLAY; m_ph = P_PAUSE;
          end
        end
        P_PAUSE: if (pa_ev != 0) m_ph = m_ret;
        default: m_ph = P_IDLE;
      endcase
      st_ev = (bus.START_BTN && st_prev == 0) ? 1 : 0;
      pa_ev = (bus.PAUSE_BTN && pa_prev == 0) ? 1 : 0;
      st_prev = bus.START_BTN ? 1 : 0;
      pa_prev = bus.PAUSE_BTN ? 1 : 0;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge VGA_CLOCK) begin
    if (chk_en) begin
      chk("m_state",   int'(bus.STATE),   m_ph);
      chk("m_score_a", int'(bus.SCORE_A), m_sa);
      chk("m_score_b", int'(bus.SCORE_B), m_sb);
      chk("m_serve",   int'(bus.SERVE),   m_srv);
      chk("m_dir",     int'(bus.SERVE_DIR), m_dir);
      chk("m_ball_en", int'(bus.BALL_ENABLE), (m_ph == P_PLAY) ? 1 : 0);
      chk("m_over",    int'(bus.GAME_OVER), (m_ph == P_OVER) ? 1 : 0);
      if (m_ph == P_OVER) chk("m_winner", int'(bus.WINNER), m_win);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge VGA_CLOCK);
      #2;
    end
  endtask

  task automatic tick();
    bus.FRAME_TICK = 1'b1; step(1); bus.FRAME_TICK = 1'b0; step(1);
  endtask

  task automatic miss(input bit a, input bit b);
    bus.MISS_A = a; bus.MISS_B = b; step(1); bus.MISS_A = 1'b0; bus.MISS_B = 1'b0;
  endtask

  // Rise is registered, so the FSM reacts on the second edge after the press
  task automatic press_pause();
    bus.PAUSE_BTN = 1'b1; step(2); bus.PAUSE_BTN = 1'b0; step(1);
  endtask

  task automatic press_start();
    bus.START_BTN = 1'b1; step(2); bus.START_BTN = 1'b0; step(1);
  endtask

  // Two ticks from SERVE_WAIT; leaves the bench one cycle into PLAY
  task automatic serve();
    tick();
    bus.FRAME_TICK = 1'b1; step(1); bus.FRAME_TICK = 1'b0;
  endtask

  initial begin
    RESET = 1'b1;
    bus.FRAME_TICK = 1'b0; bus.START_BTN = 1'b1; bus.PAUSE_BTN = 1'b0;
    bus.MISS_A = 1'b0; bus.MISS_B = 1'b0;
    step(1);
    chk_en = 1'b1;
    step(2);
    chk("rst_state", int'(bus.STATE), 0);
    chk("rst_serve", int'(bus.SERVE), 0);
    RESET = 1'b0;

    // 1: START held through reset gives no edge
    step(4);
    chk("t1_held_idle", int'(bus.STATE), 0);
    bus.START_BTN = 1'b0; step(1);
    bus.START_BTN = 1'b1; step(2);
    chk("t1_serve_wait", int'(bus.STATE), 1);
    chk("t1_scores", int'(bus.SCORE_A) + int'(bus.SCORE_B), 0);
    bus.START_BTN = 1'b0;

    // 2: two ticks -> single-cycle SERVE, PLAY
    tick();
    chk("t2_one_tick", int'(bus.STATE), 1);
    bus.FRAME_TICK = 1'b1; step(1); bus.FRAME_TICK = 1'b0;
    chk("t2_serve", int'(bus.SERVE), 1);
    chk("t2_play", int'(bus.STATE), 2);
    chk("t2_ball_en", int'(bus.BALL_ENABLE), 1);
    chk("t2_dir", int'(bus.SERVE_DIR), 0);
    step(1);
    chk("t2_serve_width", int'(bus.SERVE), 0);

    // 3: MISS_B scores for A; simultaneous misses credit only B
    miss(1'b0, 1'b1);
    chk("t3_score_a", int'(bus.SCORE_A), 1);
    chk("t3_dir", int'(bus.SERVE_DIR), 1);
    chk("t3_wait", int'(bus.STATE), 1);
    chk("t3_ball_off", int'(bus.BALL_ENABLE), 0);
    serve();
    miss(1'b1, 1'b1);
    chk("t3_both_b", int'(bus.SCORE_B), 1);
    chk("t3_both_a", int'(bus.SCORE_A), 1);

    // 4: A reaches 3 -> GAME_OVER, further misses and PAUSE ignored
    serve(); miss(1'b0, 1'b1);
    serve(); miss(1'b0, 1'b1);
    chk("t4_over", int'(bus.GAME_OVER), 1);
    chk("t4_winner", int'(bus.WINNER), 0);
    chk("t4_score_a", int'(bus.SCORE_A), 3);
    miss(1'b1, 1'b0); step(1); miss(1'b0, 1'b1); step(1);
    press_pause();
    chk("t4_hold_b", int'(bus.SCORE_B), 1);
    chk("t4_hold_state", int'(bus.STATE), 4);
    press_start();
    chk("t4_restart", int'(bus.STATE), 1);
    chk("t4_clear_a", int'(bus.SCORE_A), 0);

    // 5: pause mid-countdown freezes it; one more tick serves after resume
    tick();
    press_pause();
    chk("t5_paused", int'(bus.STATE), 3);
    for (int i = 0; i < 5; i++) tick();
    miss(1'b1, 1'b0);
    chk("t5_still_paused", int'(bus.STATE), 3);
    chk("t5_no_score", int'(bus.SCORE_B), 0);
    press_pause();
    chk("t5_resumed", int'(bus.STATE), 1);
    bus.FRAME_TICK = 1'b1; step(1); bus.FRAME_TICK = 1'b0;
    chk("t5_serve", int'(bus.SERVE), 1);
    chk("t5_play", int'(bus.STATE), 2);

    // 6: reset while paused with SCORE_B=2
    miss(1'b1, 1'b0);
    serve(); miss(1'b1, 1'b0);
    press_pause();
    chk("t6_pre_b", int'(bus.SCORE_B), 2);
    chk("t6_pre_state", int'(bus.STATE), 3);
    RESET = 1'b1; step(1);
    chk("t6_idle", int'(bus.STATE), 0);
    chk("t6_score_b", int'(bus.SCORE_B), 0);
    chk("t6_ball_off", int'(bus.BALL_ENABLE), 0);
    chk("t6_no_serve", int'(bus.SERVE), 0);
    step(2);
    RESET = 1'b0;
    tick(); tick();
    chk("t6_stay_idle", int'(bus.STATE), 0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
